mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator-side load/store unit that drives the word-addressed data memory port (address, write data, read strobe, write strobe, read data) on behalf of the CPU datapath. It accepts byte-addressed load/store requests of byte, halfword or word size and converts byte addresses to word indices. Sub-word stores are performed as read-modify-write; loads are returned sign- or zero-extended. It sits between the execute/memory stage and the data memory.

## Interface
- No parameters; widths fixed at 32-bit data/address.
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  1  misaligned request (valid with resp_valid)
- mem_address  out  32  word index = {2'b00, addr[31:2]}
- mem_write_data  out  32  full word to write
- mem_read  out  1  read strobe; mem_data is valid combinationally in the same cycle
- mem_write  out  1  write strobe; memory writes at the rising edge ending the cycle
- mem_data  in  32  read data from memory

## Operation
- Byte lanes little-endian: byte k of a word = bits [8k+7:8k], k = addr[1:0]; halfword h = addr[1].
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. Accept on req_valid at the edge; latch the request.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) -> RESP with err.
  - Load -> READ. Word store -> WRITE. Sub-word store -> READ.
- READ: mem_read=1. Capture mem_data at the edge.
  - Load: extract and extend into resp_rdata, then go to RESP.
  - Sub-word store: merge the store lane(s) into the captured word, then go to WRITE.
- WRITE: mem_write=1, with mem_write_data = merged word (or req_wdata for word stores). Then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. There is no response back-pressure.
- req_valid is ignored whenever req_ready=0.
- mem_read and mem_write are each decoded from state AND rst_n, so no strobe is issued in a cycle where rst_n is low.

## Timing
- Acceptance edge = cycle 0.
- Load: READ in cycle 1, resp_valid in cycle 2.
- Word store: WRITE in cycle 1, resp_valid in cycle 2.
- Sub-word store: READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
- Misaligned request: resp_valid in cycle 1, with no memory strobe.
- Back-to-back: the earliest next acceptance is the cycle after RESP.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_address=0, mem_write_data=0, mem_read=0, mem_write=0.
- Reset mid-operation: the state is abandoned, no memory write occurs, and no response is issued.
- mem_address and mem_write_data are registered; they hold their last value while idle.

## Configuration
- MAU_MISALIGN_TRAP_EN defined:
  - Misaligned requests give resp_err=1 and resp_rdata=0.
  - No memory access occurs.
- Undefined:
  - Misaligned low address bits are masked to alignment (half ignores addr[0]; word ignores addr[1:0]).
  - The access proceeds normally.
  - resp_err is tied to 0.

## Structure
- Package mau_pkg:
  - size encoding constants SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - FSM state enum
  - Lane helper constants
- Sub-module mau_lane_align (combinational):
  - load path: extract plus sign/zero extend
  - store path: lane merge into the read word
- Top level holds the FSM and the registers.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> all outputs at their reset values, req_ready=1.
- Word store of 0xDEADBEEF to 0x10 -> mem_address=4, mem_write_data=0xDEADBEEF; mem_write high in cycle 1 only; resp_valid in cycle 2.
- Byte loads from 0x13, with word 4 = 0xDEADBEEF:
  - signed -> resp_rdata=0xFFFFFFDE
  - unsigned -> resp_rdata=0x000000DE
  - mem_read high only in cycle 1 in both cases.
- Halfword store of 0x1234 to 0x12 over 0xDEADBEEF -> READ then WRITE with 0x1234BEEF; resp_valid in cycle 3; req_ready=0 throughout, and a req_valid presented mid-flight is ignored.
- Word load from 0x11:
  - with MAU_MISALIGN_TRAP_EN -> resp_err=1 in cycle 1, no mem_read
  - without it -> reads word 4, resp_err=0
- Drive rst_n=0 during the WRITE cycle of a byte store -> mem_write=0, memory word unchanged, no resp_valid, unit returns to IDLE.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane widths, request record.
// Sizing helpers live here so the top and the lane aligner agree on what "aligned" means.
package mau_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef logic [1:0] mau_state_t;
    localparam mau_state_t ST_IDLE  = 2'd0;
    localparam mau_state_t ST_READ  = 2'd1;
    localparam mau_state_t ST_WRITE = 2'd2;
    localparam mau_state_t ST_RESP  = 2'd3;

    localparam int LANE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              is_unsigned;
        logic [1:0]        offset;
        logic [WORD_W-1:0] wdata;
    } mau_req_t;

    function automatic logic is_subword(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

    // Reserved size 2'b11 behaves as a word everywhere.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            default:   return offset != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return offset;
            SIZE_HALF: return {offset[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mau_if.sv
// Request/response handshake plus word-addressed data memory port of the load/store unit.
// master = CPU side and memory model, slave = the unit itself.
interface mau_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/mau_lane_align.sv
// Byte-lane steering: load extract + sign/zero extend, and sub-word store merge into a read word.
// Latency: purely combinational.
// Backpressure: none, no state.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [LANE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    always_comb begin
        byte_v    = word[{offset, 3'b000} +: LANE_W];
        half_v    = word[{offset[1], 4'b0000} +: HALF_W];
        load_data = word;
        merged    = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data = {{(WORD_W-LANE_W){~is_unsigned & byte_v[LANE_W-1]}}, byte_v};
                merged    = word;
                merged[{offset, 3'b000} +: LANE_W] = wdata[LANE_W-1:0];
            end
            SIZE_HALF: begin
                load_data = {{(WORD_W-HALF_W){~is_unsigned & half_v[HALF_W-1]}}, half_v};
                merged    = word;
                merged[{offset[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit driving a word-addressed memory; sub-word stores via read-modify-write. Option: MAU_MISALIGN_TRAP_EN.
// Latency: load/word store 2 cycles, sub-word store 3, trapped misaligned 1 (acceptance edge = cycle 0).
// Backpressure: req_ready only in IDLE, one request in flight; responses cannot be stalled.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    mau_if.slave  bus
);

    mau_state_t  state;
    mau_req_t    req_q;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        trap;
    logic        word_store;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign word_store = bus.req_write && !is_subword(bus.req_size);

`ifdef MAU_MISALIGN_TRAP_EN
    logic err_q;
    assign trap         = misaligned(bus.req_size, bus.req_addr[1:0]);
    assign bus.resp_err = err_q;
`else
    assign trap         = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    mau_lane_align u_lane_align (
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .offset      (req_q.offset),
        .word        (bus.mem_data),
        .wdata       (req_q.wdata),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        req_q.write       <= bus.req_write;
                        req_q.size        <= bus.req_size;
                        req_q.is_unsigned <= bus.req_unsigned;
                        // Masking is a no-op for aligned requests; trapped ones never use it.
                        req_q.offset      <= align_offset(bus.req_size, bus.req_addr[1:0]);
                        req_q.wdata       <= bus.req_wdata;
                        addr_q            <= {2'b00, bus.req_addr[31:2]};
                        rdata_q           <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
                        err_q             <= trap;
`endif
                        if (word_store) begin
                            wdata_q <= bus.req_wdata;
                        end
                        if (trap) begin
                            state <= ST_RESP;
                        end else if (word_store) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (req_q.write) begin
                        wdata_q <= merged;
                        state   <= ST_WRITE;
                    end else begin
                        rdata_q <= load_data;
                        state   <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are gated by rst_n so a reset cycle can never touch memory.
    assign bus.req_ready      = (state == ST_IDLE);
    assign bus.mem_read       = rst_n && (state == ST_READ);
    assign bus.mem_write      = rst_n && (state == ST_WRITE);
    assign bus.resp_valid     = rst_n && (state == ST_RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random requests against a byte-level reference memory.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic fill_mem;

    mau_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_mem   [64];
    logic [31:0] init_mem [64];
    logic [31:0] ref_mem  [64];
    int n_checks = 0;
    int n_errors = 0;

    assign bus.mem_data = (bus.mem_address < 32'd64) ? tb_mem[bus.mem_address[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (fill_mem) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_mem[i];
        end else if (bus.mem_write && bus.mem_address < 32'd64) begin
            tb_mem[bus.mem_address[5:0]] <= bus.mem_write_data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_junk();
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom_range(0, 255);
        bus.req_wdata    = $urandom;
    endtask

    // Issue one request, watch it to completion, and compare against the reference memory.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input int addr, input logic [31:0] wd, output logic [31:0] rd_o);
        int nb, off, ea, wi, sh, exp_lat, exp_nrd, exp_nwr, exp_rdc, exp_wrc;
        int lat, nrd, nwr, nrdy, rdc, wrc;
        logic        trapped, exp_err, got_err, done;
        logic [31:0] m, w, exp_rd, got_rd, adr_seen, wd_seen;

        nb      = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        off     = addr % nb;
        trapped = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
        trapped = (off != 0);
`endif
        ea = addr - off;
        wi = ea / 4;
        sh = 8 * (ea % 4);
        m  = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        w  = ref_mem[wi];
        exp_rd = 32'h0; exp_err = 1'b0; exp_rdc = 0; exp_wrc = 0;
        if (trapped) begin
            exp_err = 1'b1; exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
        end else if (!wr) begin
            exp_rd = (w >> sh) & m;
            if (!uns && nb < 4 && ((exp_rd >> (8 * nb - 1)) & 32'h1) == 32'h1) exp_rd = exp_rd | ~m;
            exp_lat = 2; exp_nrd = 1; exp_nwr = 0; exp_rdc = 1;
        end else begin
            ref_mem[wi] = (w & ~(m << sh)) | ((wd & m) << sh);
            exp_nwr = 1;
            exp_nrd = (nb < 4) ? 1 : 0;
            exp_lat = (nb < 4) ? 3 : 2;
            exp_rdc = (nb < 4) ? 1 : 0;
            exp_wrc = (nb < 4) ? 2 : 1;
        end

        @(negedge clk);
        check_val("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);

        lat = 0; nrd = 0; nwr = 0; nrdy = 0; rdc = 0; wrc = 0; done = 1'b0;
        got_rd = 32'h0; got_err = 1'b0; adr_seen = 32'h0; wd_seen = 32'h0;
        for (int c = 1; c <= 6 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_read)  begin nrd++; rdc = c; adr_seen = bus.mem_address; end
            if (bus.mem_write) begin nwr++; wrc = c; adr_seen = bus.mem_address; wd_seen = bus.mem_write_data; end
            if (bus.req_ready) nrdy++;
            if (bus.resp_valid) begin
                lat = c; got_rd = bus.resp_rdata; got_err = bus.resp_err; done = 1'b1;
                bus.req_valid = 1'b0;
            end else begin
                drive_junk();
            end
        end

        check_val("latency", lat, exp_lat);
        check_val("rd_strobes", nrd, exp_nrd);
        check_val("wr_strobes", nwr, exp_nwr);
        check_val("rd_cycle", rdc, exp_rdc);
        check_val("wr_cycle", wrc, exp_wrc);
        check_val("ready_busy", nrdy, 0);
        check_val("resp_rdata", got_rd, exp_rd);
        check_val("resp_err", 32'(got_err), 32'(exp_err));
        if (exp_nrd + exp_nwr > 0) check_val("mem_address", adr_seen, wi);
        if (exp_nwr > 0) check_val("mem_write_data", wd_seen, ref_mem[wi]);
        check_val("mem_word", tb_mem[wi], ref_mem[wi]);
        rd_o = got_rd;
    endtask

    initial begin
        logic [31:0] rd;
        int seen;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        fill_mem = 1'b1;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_val("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check_val("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check_val("rst_mem_address", bus.mem_address, 32'h0);
        check_val("rst_mem_wdata", bus.mem_write_data, 32'h0);
        check_val("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check_val("rst_mem_write", 32'(bus.mem_write), 32'd0);
        for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
        fill_mem = 1'b0;
        rst_n    = 1'b1;

        do_req(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, rd);
        check_val("ws_mem4", tb_mem[4], 32'hDEAD_BEEF);
        do_req(1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'h0, rd);
        check_val("lb_signed", rd, 32'hFFFF_FFDE);
        do_req(1'b0, SIZE_BYTE, 1'b1, 32'h13, 32'h0, rd);
        check_val("lb_unsigned", rd, 32'h0000_00DE);
        do_req(1'b1, SIZE_HALF, 1'b0, 32'h12, 32'h0000_1234, rd);
        check_val("sh_mem4", tb_mem[4], 32'h1234_BEEF);
        do_req(1'b0, SIZE_WORD, 1'b0, 32'h11, 32'h0, rd);
`ifdef MAU_MISALIGN_TRAP_EN
        check_val("lw_misaligned", rd, 32'h0);
`else
        check_val("lw_misaligned", rd, 32'h1234_BEEF);
`endif

        for (int n = 0; n < 150; n++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 255), $urandom, rd);
        end

        // Reset landing on the WRITE cycle of a byte store must suppress the write and the response.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SIZE_BYTE;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h21; bus.req_wdata = 32'h0000_00A5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_val("mr_read_c1", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        check_val("mr_write_c2", 32'(bus.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mr_write_gated", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("mr_ready", 32'(bus.req_ready), 32'd1);
        check_val("mr_mem8", tb_mem[8], ref_mem[8]);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_read || bus.mem_write) seen++;
        end
        check_val("mr_no_resp", seen, 0);
        check_val("mr_idle", 32'(bus.req_ready), 32'd1);
        check_val("mr_mem8_after", tb_mem[8], ref_mem[8]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
